// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: load-use and branch handling,
// EX forwarding select, mul/div start/done sequencing with a timeout watchdog.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned MD_TIMEOUT = 40,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemReadE,
  input  logic              PCSrcE,
  input  logic              MdReqE,
  input  logic              MdDone,
  output logic              en_nF,
  output logic              en_nD,
  output logic              FlushD,
  output logic              FlushE,
  output logic              StallE,
  output logic              FlushM,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              md_start,
  output logic              md_busy,
  output logic              md_err,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;
  localparam logic [7:0] TIMER_LAST = 8'(MD_TIMEOUT - 1);

  typedef enum logic {
    IDLE,
    MD_BUSY
  } state_t;

  state_t            state;
  logic [7:0]        timer;
  logic              lw_stall;
  logic              md_timeout;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;

  // M-stage producer wins over W since it holds the younger value
  always_comb begin
    fwd_a = FWD_RF;
    if (RegWriteM && (RdM != '0) && (RdM == Rs1E))
      fwd_a = FWD_M;
    else if (RegWriteW && (RdW != '0) && (RdW == Rs1E))
      fwd_a = FWD_W;
  end

  always_comb begin
    fwd_b = FWD_RF;
    if (RegWriteM && (RdM != '0) && (RdM == Rs2E))
      fwd_b = FWD_M;
    else if (RegWriteW && (RdW != '0) && (RdW == Rs2E))
      fwd_b = FWD_W;
  end

  always_comb begin
    lw_stall   = MemReadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
    md_timeout = (state == MD_BUSY) && !MdDone && (timer == TIMER_LAST);
    md_busy    = (state == MD_BUSY);
  end

  // Pipeline controls; everything is forced inactive while reset is asserted
  always_comb begin
    en_nF     = 1'b0;
    en_nD     = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    StallE    = 1'b0;
    FlushM    = 1'b0;
    md_start  = 1'b0;
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (rst_n) begin
      ForwardAE = fwd_a;
      ForwardBE = fwd_b;
      unique case (state)
        IDLE: begin
          if (MdReqE && !PCSrcE) begin
            md_start = 1'b1;
            en_nF    = 1'b1;
            en_nD    = 1'b1;
            StallE   = 1'b1;
            FlushM   = 1'b1;
          end else begin
            en_nF  = lw_stall;
            en_nD  = lw_stall;
            FlushE = lw_stall | PCSrcE;
            FlushD = PCSrcE;
          end
        end
        MD_BUSY: begin
          // Release on done/timeout lets the EX result advance into M at this edge
          if (!MdDone && !md_timeout) begin
            en_nF  = 1'b1;
            en_nD  = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= '0;
      md_err    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (en_nD && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      unique case (state)
        IDLE: begin
          if (md_start) begin
            state <= MD_BUSY;
            timer <= '0;
          end
        end
        MD_BUSY: begin
          if (MdDone) begin
            state <= IDLE;
          end else if (md_timeout) begin
            state  <= IDLE;
            md_err <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
